// File: rtl/midori_session_if.sv
`default_nettype none
// ============================================================================
// Module  : midori_session_if
// Brief   : Handshake and datapath-control bundle for midori_session_ctrl.
// Rev     : 1.0
// ============================================================================
interface midori_session_if #(
  parameter int NUM_ROUNDS    = 16,
  parameter int CYC_PER_ROUND = 2
);
  localparam int RW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
  localparam int PW = (CYC_PER_ROUND > 1) ? $clog2(CYC_PER_ROUND) : 1;

  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
`ifdef MIDORI_CTRL_PRNG_STALL_EN
  logic          rnd_valid;
`endif
  logic          start_sel;
  logic          state_en;
  logic [RW-1:0] round;
  logic [PW-1:0] phase;
  logic          last_round;
  logic          busy;

  modport master (
`ifdef MIDORI_CTRL_PRNG_STALL_EN
    output rnd_valid,
`endif
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  start_sel,
    input  state_en,
    input  round,
    input  phase,
    input  last_round,
    input  busy
  );

  modport slave (
`ifdef MIDORI_CTRL_PRNG_STALL_EN
    input  rnd_valid,
`endif
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid,
    output start_sel,
    output state_en,
    output round,
    output phase,
    output last_round,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/midori_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : midori_session_ctrl
// Brief   : Flow-controlled round sequencer for the shared Midori64 TI datapath.
//           Optional MIDORI_CTRL_PRNG_STALL_EN stalls on PRNG rnd_valid.
// Rev     : 1.0
// ============================================================================
module midori_session_ctrl #(
  parameter int NUM_ROUNDS    = 16,
  parameter int CYC_PER_ROUND = 2
) (
  input  logic             clk,
  input  logic             rst,
  midori_session_if.slave  bus
);
  localparam int RW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
  localparam int PW = (CYC_PER_ROUND > 1) ? $clog2(CYC_PER_ROUND) : 1;

  localparam logic [RW-1:0] c_LAST_ROUND = RW'(NUM_ROUNDS - 1);
  localparam logic [PW-1:0] c_LAST_PHASE = PW'(CYC_PER_ROUND - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [RW-1:0] r_round;
  logic [PW-1:0] r_phase;
  logic          r_last_round;

  logic          w_go;
  logic          w_accept;
  logic          w_phase_wrap;
  logic          w_final;
  logic [1:0]    w_state_nxt;
  logic [RW-1:0] w_round_nxt;
  logic [PW-1:0] w_phase_nxt;

`ifdef MIDORI_CTRL_PRNG_STALL_EN
  assign w_go = bus.rnd_valid;
`else
  assign w_go = 1'b1;
`endif

  assign w_accept     = !rst && (r_state == c_IDLE) && w_go && bus.in_valid;
  // With a single stage per round the phase never leaves 0 and every go wraps.
  assign w_phase_wrap = (r_phase == c_LAST_PHASE);
  assign w_final      = w_phase_wrap && (r_round == c_LAST_ROUND);

  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    w_phase_nxt = r_phase;
    case (r_state)
      c_IDLE: begin
        if (w_accept) begin
          w_state_nxt = c_RUN;
        end
      end
      c_RUN: begin
        if (w_go) begin
          if (w_final) begin
            w_state_nxt = c_DONE;
            w_round_nxt = '0;
            w_phase_nxt = '0;
          end else if (w_phase_wrap) begin
            w_round_nxt = r_round + RW'(1);
            w_phase_nxt = '0;
          end else begin
            w_phase_nxt = r_phase + PW'(1);
          end
        end
      end
      c_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = c_IDLE;
        end
      end
      default: begin
        w_state_nxt = c_IDLE;
        w_round_nxt = '0;
        w_phase_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= c_IDLE;
      r_round      <= '0;
      r_phase      <= '0;
      r_last_round <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_round      <= w_round_nxt;
      r_phase      <= w_phase_nxt;
      r_last_round <= (w_state_nxt == c_RUN) && (w_round_nxt == c_LAST_ROUND);
    end
  end

  assign bus.in_ready   = !rst && (r_state == c_IDLE) && w_go;
  assign bus.start_sel  = w_accept;
  assign bus.state_en   = w_accept || (!rst && (r_state == c_RUN) && w_go);
  assign bus.out_valid  = !rst && (r_state == c_DONE);
  assign bus.busy       = !rst && (r_state != c_IDLE);
  assign bus.round      = r_round;
  assign bus.phase      = r_phase;
  assign bus.last_round = r_last_round;

endmodule
`default_nettype wire
